// File: rtl/add_arbiter.sv
// add_arbiter: round-robin scheduler sharing one registered signed adder
// among N requesters, with a single backpressured result channel.

// Per-requester operand slice and sign extension to the result width.
module add_arbiter_lane #(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int OW = 17
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [OW-1:0] a_ext,
  output logic [OW-1:0] b_ext
);
  // OW is always at least one bit wider than either operand
  assign a_ext = {{(OW-AW){a[AW-1]}}, a};
  assign b_ext = {{(OW-BW){b[BW-1]}}, b};
endmodule

module add_arbiter #(
  parameter  int N  = 4,
  parameter  int AW = 16,
  parameter  int BW = 16,
  localparam int OW = ((AW > BW) ? AW : BW) + 1,
  localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*AW-1:0]      req_a,
  input  logic [N*BW-1:0]      req_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [OW-1:0] res_data,
  output logic [IW-1:0]        res_id
);

  typedef struct packed {
    logic signed [OW-1:0] data;
    logic [IW-1:0]        id;
  } res_t;

  res_t                  res_q;
  logic [IW-1:0]         ptr;
  logic [N-1:0][OW-1:0]  a_ext;
  logic [N-1:0][OW-1:0]  b_ext;
  logic [N-1:0]          grant;
  logic [IW-1:0]         gidx;
  logic [IW:0]           idx;
  logic                  can_issue;
  logic                  issue;
  logic [OW-1:0]         a_sel;
  logic [OW-1:0]         b_sel;
  logic signed [OW-1:0]  sum;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      add_arbiter_lane #(.AW(AW), .BW(BW), .OW(OW)) u_lane (
        .a     (req_a[gi*AW +: AW]),
        .b     (req_b[gi*BW +: BW]),
        .a_ext (a_ext[gi]),
        .b_ext (b_ext[gi])
      );
    end
  endgenerate

  // Rotating search from ptr; wrap is explicit at N so non-power-of-two N
  // never visits an index outside 0..N-1.
  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if ((grant == '0) && req_valid[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        gidx               = idx[IW-1:0];
      end
    end
  end

  // The result register can take a new sum when empty or draining this edge;
  // reset also blocks acceptance so nothing handshakes while held in reset.
  assign can_issue = !res_valid || res_ready;
  assign req_ready = grant & {N{can_issue && rst_n}};
  assign issue     = |req_ready;

  // One-hot operand mux feeding the single shared adder.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | a_ext[i];
        b_sel = b_sel | b_ext[i];
      end
    end
  end

  assign sum = $signed(a_sel) + $signed(b_sel);

  // Result register and priority pointer; pointer only moves on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_q     <= '0;
      ptr       <= '0;
    end else if (issue) begin
      res_valid  <= 1'b1;
      res_q.data <= sum;
      res_q.id   <= gidx;
      ptr        <= (gidx == IW'(N-1)) ? '0 : gidx + 1'b1;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  assign res_data = res_q.data;
  assign res_id   = res_q.id;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: scoreboard on the N=4 16/16 instance, plus direct
// checks on a N=3 8/12 instance for mixed widths and non-power-of-two wrap.
module tb_add_arbiter;

  logic        clk;
  logic        rst_n;

  // main instance
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [63:0]        req_a;
  logic [63:0]        req_b;
  logic               res_valid;
  logic               res_ready;
  logic signed [16:0] res_data;
  logic [1:0]         res_id;

  // mixed-width instance
  logic [2:0]         m_req_valid;
  logic [2:0]         m_req_ready;
  logic [23:0]        m_req_a;
  logic [35:0]        m_req_b;
  logic               m_res_valid;
  logic               m_res_ready;
  logic signed [12:0] m_res_data;
  logic [1:0]         m_res_id;

  add_arbiter #(.N(4), .AW(16), .BW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
  );

  add_arbiter #(.N(3), .AW(8), .BW(12)) dut_mw (
    .clk(clk), .rst_n(rst_n),
    .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_a(m_req_a), .req_b(m_req_b),
    .res_valid(m_res_valid), .res_ready(m_res_ready),
    .res_data(m_res_data), .res_id(m_res_id)
  );

  typedef struct packed {
    logic [16:0] data;
    logic [1:0]  id;
  } exp_t;

  exp_t        sb[$];
  logic [16:0] exp_sum [4];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the oldest expectation whenever the result port transfers.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: result id=%0d data=0x%0h with nothing expected", res_id, res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", {15'b0, res_data}, {15'b0, e.data});
        chk("res_id", {30'b0, res_id}, {30'b0, e.id});
      end
    end
  end

  // One cycle of stimulus: drive, check grant mid-cycle, record expectation.
  task automatic step(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy);
    req_valid = v;
    res_ready = rr;
    @(negedge clk);
    chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
    for (int i = 0; i < 4; i++)
      if (exp_rdy[i]) sb.push_back({exp_sum[i], 2'(i)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // operand table with hand-computed 17-bit sums
    req_a = {16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF};
    req_b = {16'hFFFE, 16'h0001, 16'h8000, 16'h7FFF};
    exp_sum[0] = 17'h0FFFE;  // 32767 + 32767
    exp_sum[1] = 17'h10000;  // -32768 + -32768
    exp_sum[2] = 17'h00000;  // -1 + 1
    exp_sum[3] = 17'h01232;  // 0x1234 - 2
    req_valid   = '0;
    res_ready   = 1'b1;
    m_req_valid = '0;
    m_req_a     = '0;
    m_req_b     = '0;
    m_res_ready = 1'b1;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", {15'b0, res_data}, 32'd0);
    chk("rst_res_id", {30'b0, res_id}, 32'd0);
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // sign/width vectors, one requester at a time
    step(4'b0001, 1'b1, 4'b0001);
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b0100, 1'b1, 4'b0100);
    step(4'b0000, 1'b1, 4'b0000);  // idle: ptr stays at 3

    // full contention, no bubbles
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b1111, 1'b1, 4'b0001);
    step(4'b1111, 1'b1, 4'b0010);
    step(4'b1111, 1'b1, 4'b0100);
    step(4'b1111, 1'b1, 4'b1000);
    step(4'b1111, 1'b1, 4'b0001);

    // sparse fairness between requesters 1 and 3
    step(4'b1010, 1'b1, 4'b0010);
    step(4'b1010, 1'b1, 4'b1000);
    step(4'b1010, 1'b1, 4'b0010);
    step(4'b1010, 1'b1, 4'b1000);

    // backpressure: hold for 5 cycles, result stays put
    step(4'b0001, 1'b1, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 1'b0, 4'b0000);
      chk("bp_res_valid", {31'b0, res_valid}, 32'd1);
      chk("bp_res_data", {15'b0, res_data}, 32'h0FFFE);
      chk("bp_res_id", {30'b0, res_id}, 32'd0);
    end
    step(4'b1111, 1'b1, 4'b0010);  // drain + issue in the same edge
    step(4'b0000, 1'b1, 4'b0000);
    step(4'b0000, 1'b1, 4'b0000);
    chk("drained_valid", {31'b0, res_valid}, 32'd0);

    // reset mid-stream
    step(4'b1111, 1'b1, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("midrst_res_data", {15'b0, res_data}, 32'd0);
    chk("midrst_res_id", {30'b0, res_id}, 32'd0);
    chk("midrst_req_ready", {28'b0, req_ready}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(4'b1110, 1'b1, 4'b0010);  // ptr back at 0: lowest valid index wins
    step(4'b0000, 1'b1, 4'b0000);

    // mixed widths on N=3: grant requester 2, pointer wraps to 0
    m_req_a[16 +: 8]  = 8'h80;
    m_req_b[24 +: 12] = 12'h7FF;
    m_req_valid = 3'b100;
    #1;
    chk("mw_ready0", {29'b0, m_req_ready}, 32'b100);
    @(posedge clk);
    #1;
    chk("mw_valid0", {31'b0, m_res_valid}, 32'd1);
    chk("mw_data0", {19'b0, m_res_data}, 32'h077F);
    chk("mw_id0", {30'b0, m_res_id}, 32'd2);
    m_req_a[0 +: 8]  = 8'h7F;
    m_req_b[0 +: 12] = 12'h800;
    m_req_valid = 3'b011;
    #1;
    chk("mw_ready1", {29'b0, m_req_ready}, 32'b001);
    @(posedge clk);
    #1;
    chk("mw_data1", {19'b0, m_res_data}, 32'h187F);  // 127 - 2048
    chk("mw_id1", {30'b0, m_res_id}, 32'd0);
    m_req_valid = '0;
    @(posedge clk);
    #1;
    chk("mw_drain", {31'b0, m_res_valid}, 32'd0);

    repeat (2) @(posedge clk);
    chk("sb_leftover", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin scheduler that shares one registered signed adder among N requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes a full-precision sum with bit growth, and returns it with the requester index on a single result channel that supports backpressure. It sits between independent datapath clients and the shared arithmetic resource, so only one adder is instantiated.

## Interface
- N, 4: number of requesters, 2..16.
- AW, 16: operand A width (signed).
- BW, 16: operand B width (signed).
- OW, derived localparam: max(AW,BW)+1, result width.
- IW, derived localparam: max(1, clog2(N)), requester index width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  N  bit i: requester i presents an operation.
- req_ready  out  N  bit i: requester i accepted this cycle; one-hot or zero.
- req_a  in  N*AW  packed operand A; slice i = bits [i*AW +: AW].
- req_b  in  N*BW  packed operand B; slice i = bits [i*BW +: BW].
- res_valid  out  1  result register holds a valid sum.
- res_ready  in  1  consumer accepts result.
- res_data  out  OW  signed sum a+b.
- res_id  out  IW  index of the requester that produced res_data.

## Operation
- Transfer on a request port: req_valid[i] && req_ready[i] on a rising edge. Transfer on the result port: res_valid && res_ready.
- can_issue = !res_valid || res_ready. When can_issue is 0, all req_ready bits are 0.
- Arbitration is combinational from req_valid and the priority pointer ptr (width IW).
  - Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - The first requester with valid set is granted. req_ready = grant one-hot & {N{can_issue}}.
- On an accepted request from requester g:
  - res_data <= sext(req_a[g]) + sext(req_b[g]). Both operands are sign-extended to OW, so overflow cannot occur.
  - res_id <= g.
  - res_valid <= 1.
  - ptr <= (g==N-1) ? 0 : g+1.
- No issue, result consumed: res_valid <= 0. res_data and res_id hold their last values.
- No issue, result not consumed: all result outputs hold and stay stable.
- ptr changes only on an accepted request.
- A requester with no valid request is skipped and does not lose its position relative to the others.
- Requesters may drop req_valid at any time. Operands are sampled only in the transfer cycle.
- Non-power-of-two N: pointer wrap is explicit at N-1. Index values N..2^IW-1 are never produced.

## Timing
- Reset (async, rst_n=0): res_valid=0, res_data=0, res_id=0, ptr=0.
- With res_valid=0 after reset, req_ready is combinationally live from req_valid.
- Latency: a request accepted at edge k appears on res_data/res_valid after edge k.
- Throughput: one operation per cycle while res_ready=1.
- Simultaneous accept and result drain in one cycle is required. The new result replaces the old one with no bubble.
- Combinational paths:
  - req_valid → req_ready.
  - res_ready → req_ready.
  - No path from res_ready to res_data.
- Reset asserted mid-stream:
  - The in-flight result is discarded and ptr returns to 0.
  - req_ready is forced to 0 while rst_n=0.
- All request ports idle: res_valid drains normally and ptr is unchanged.

## Test plan
- Sign/width, N=4, AW=BW=16:
  - Req0 a=0x7FFF, b=0x7FFF → res_data=0x0FFFE, res_id=0.
  - Req0 a=0x8000, b=0x8000 → res_data=0x10000 (−65536).
  - a=0xFFFF, b=0x0001 → 0x00000.
- Full contention: all four req_valid held high, res_ready=1 → grant order 0,1,2,3,0,…, one per cycle, res_id tracks grants one cycle later, no bubbles.
- Sparse fairness: req1 and req3 high, ptr=0 → grants 1,3,1,3. req0 and req2 are never acked.
- Backpressure: result pending and res_ready=0 for 5 cycles → req_ready=0, res_data/res_id/res_valid stable. Raise res_ready → drain and new issue in the same edge.
- Mixed widths: AW=8, BW=12 (OW=13), a=0x80, b=0x7FF → res_data=0x077F (1919).
- Reset mid-stream: pull rst_n low during continuous traffic → res_valid=0, res_data=0, res_id=0 immediately, no req_ready. Release → first grant goes to the lowest-index valid requester.
